// File: rtl/thumb_pkg.sv
// Shared types, constants and ITSTATE helpers for the Thumb halfword decode front.
// Imported by the classifier and the tracker top.
package thumb_pkg;

    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_BCOND = 2'd1,
        CLS_BUNC  = 2'd2,
        CLS_IT    = 2'd3
    } inst_class_e;

    localparam logic [3:0] COND_AL = 4'hE;

    // First-halfword [15:11] values that introduce a 32-bit Thumb-2 instruction
    localparam logic [4:0] T32_PFX_A = 5'b11101;
    localparam logic [4:0] T32_PFX_B = 5'b11110;
    localparam logic [4:0] T32_PFX_C = 5'b11111;

    function automatic logic is_t32_prefix(input logic [15:0] hw);
        return (hw[15:11] == T32_PFX_A) || (hw[15:11] == T32_PFX_B) ||
               (hw[15:11] == T32_PFX_C);
    endfunction

    // Step ITSTATE after one instruction of an IT block; the base condition
    // [7:5] is kept while [4:0] shifts so [4] becomes the next condition LSB.
    function automatic logic [7:0] it_advance(input logic [7:0] itstate);
        if (itstate[2:0] == 3'b000) begin
            return 8'h00;
        end
        return {itstate[7:5], itstate[3:0], 1'b0};
    endfunction

endpackage

// File: rtl/thumb_cond_tracker_if.sv
// Halfword input stream and instruction output stream of the condition tracker.
// master = upstream fetch / downstream decode side, slave = the tracker.
interface thumb_cond_tracker_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_hw;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_is32;
    logic [1:0]  out_class;
    logic [3:0]  out_cond;
    logic        out_in_it;
    logic        out_it_last;
    logic        out_err;

    modport master (
        output in_valid, in_hw, out_ready,
        input  in_ready, out_valid, out_inst, out_is32, out_class, out_cond,
               out_in_it, out_it_last, out_err
    );

    modport slave (
        input  in_valid, in_hw, out_ready,
        output in_ready, out_valid, out_inst, out_is32, out_class, out_cond,
               out_in_it, out_it_last, out_err
    );
endinterface

// File: rtl/thumb_hw_classify.sv
// Combinational classifier: assembled instruction -> class, encoded condition,
// IT field and the IT-encoding sanity flag.
module thumb_hw_classify
    import thumb_pkg::*;
#(
    parameter bit IT_EN = 1'b1
) (
    input  logic [31:0] i_inst,
    input  logic        i_is32,
    output inst_class_e o_class,
    output logic [3:0]  o_cond,
    output logic [7:0]  o_it_state,
    output logic        o_it_bad
);

    logic [15:0] w_hw1;
    logic [15:0] w_hw2;
    logic        w_unused;

    assign w_hw1 = i_inst[31:16];
    assign w_hw2 = i_inst[15:0];
    assign w_unused = &{1'b0, w_hw1[10], w_hw1[5:0]};

    always_comb begin
        o_class    = CLS_OTHER;
        o_cond     = COND_AL;
        o_it_state = w_hw2[7:0];
        o_it_bad   = 1'b0;
        if (i_is32) begin
            if (w_hw1[15:11] == T32_PFX_B && w_hw2[15:14] == 2'b10) begin
                if (w_hw2[12]) begin
                    o_class = CLS_BUNC;
                end else if (w_hw1[9:7] != 3'b111) begin
                    o_class = CLS_BCOND;
                    o_cond  = w_hw1[9:6];
                end
            end
        end else begin
            // Cond 1110/1111 in the B<c> space are UDF/SVC, not branches
            if (w_hw2[15:12] == 4'b1101 && w_hw2[11:9] != 3'b111) begin
                o_class = CLS_BCOND;
                o_cond  = w_hw2[11:8];
            end else if (w_hw2[15:11] == 5'b11100) begin
                o_class = CLS_BUNC;
            end else if (IT_EN && w_hw2[15:8] == 8'hBF && w_hw2[3:0] != 4'h0) begin
                o_class  = CLS_IT;
                o_it_bad = (w_hw2[7:4] == 4'hF) ||
                           (w_hw2[7:4] == 4'hE && w_hw2[3:0] != 4'b1000);
            end
        end
    end

endmodule

// File: rtl/thumb_cond_tracker.sv
// Assembles 16/32-bit Thumb instructions from a halfword stream, tracks ITSTATE
// and emits each instruction with its effective condition through one output register.
module thumb_cond_tracker
    import thumb_pkg::*;
#(
    parameter bit T2_EN = 1'b1,
    parameter bit IT_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    thumb_cond_tracker_if.slave  bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HALF = 1'b1
    } asm_state_e;

    asm_state_e  r_state;
    logic [15:0] r_hw_hold;
    logic [7:0]  r_itstate;
    logic        r_out_valid;
    logic [31:0] r_out_inst;
    logic        r_out_is32;
    inst_class_e r_out_class;
    logic [3:0]  r_out_cond;
    logic        r_out_in_it;
    logic        r_out_it_last;
    logic        r_out_err;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_is_prefix;
    logic        w_is32;
    logic [31:0] w_inst;
    inst_class_e w_class;
    logic [3:0]  w_cond;
    logic [7:0]  w_it_state;
    logic        w_it_bad;
    logic        w_in_it;
    logic [3:0]  w_emit_cond;
    logic        w_emit_in_it;
    logic        w_emit_last;
    logic        w_emit_err;
    logic [7:0]  w_itstate_next;

    assign w_in_ready  = !r_out_valid || bus.out_ready;
    assign w_accept    = bus.in_valid && w_in_ready && !flush;
    assign w_is_prefix = T2_EN && is_t32_prefix(bus.in_hw);
    assign w_is32      = (r_state == ST_HALF);
    assign w_inst      = w_is32 ? {r_hw_hold, bus.in_hw} : {16'h0000, bus.in_hw};
    assign w_in_it     = (r_itstate[3:0] != 4'h0);

    thumb_hw_classify #(
        .IT_EN (IT_EN)
    ) u_classify (
        .i_inst     (w_inst),
        .i_is32     (w_is32),
        .o_class    (w_class),
        .o_cond     (w_cond),
        .o_it_state (w_it_state),
        .o_it_bad   (w_it_bad)
    );

    // Effective condition and ITSTATE successor for the instruction being emitted
    always_comb begin
        w_emit_cond    = w_cond;
        w_emit_in_it   = 1'b0;
        w_emit_last    = 1'b0;
        w_emit_err     = 1'b0;
        w_itstate_next = r_itstate;
        if (w_class == CLS_IT && !w_in_it) begin
            w_itstate_next = w_it_state;
            w_emit_cond    = COND_AL;
            w_emit_err     = w_it_bad;
        end else if (w_in_it) begin
            w_emit_cond    = r_itstate[7:4];
            w_emit_in_it   = 1'b1;
            w_emit_last    = (r_itstate[2:0] == 3'b000);
            w_itstate_next = it_advance(r_itstate);
            // A nested IT still consumes one slot; it never reloads ITSTATE
            w_emit_err     = (w_class == CLS_BCOND) || (w_class == CLS_IT) ||
                             (w_class == CLS_BUNC && r_itstate[2:0] != 3'b000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_hw_hold     <= 16'h0000;
            r_itstate     <= 8'h00;
            r_out_valid   <= 1'b0;
            r_out_inst    <= 32'h0000_0000;
            r_out_is32    <= 1'b0;
            r_out_class   <= CLS_OTHER;
            r_out_cond    <= 4'h0;
            r_out_in_it   <= 1'b0;
            r_out_it_last <= 1'b0;
            r_out_err     <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_itstate   <= 8'h00;
            r_out_valid <= 1'b0;
        end else if (w_in_ready) begin
            if (w_accept && r_state == ST_IDLE && w_is_prefix) begin
                r_state     <= ST_HALF;
                r_hw_hold   <= bus.in_hw;
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_state       <= ST_IDLE;
                r_itstate     <= w_itstate_next;
                r_out_valid   <= 1'b1;
                r_out_inst    <= w_inst;
                r_out_is32    <= w_is32;
                r_out_class   <= w_class;
                r_out_cond    <= w_emit_cond;
                r_out_in_it   <= w_emit_in_it;
                r_out_it_last <= w_emit_last;
                r_out_err     <= w_emit_err;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_inst    = r_out_inst;
    assign bus.out_is32    = r_out_is32;
    assign bus.out_class   = r_out_class;
    assign bus.out_cond    = r_out_cond;
    assign bus.out_in_it   = r_out_in_it;
    assign bus.out_it_last = r_out_it_last;
    assign bus.out_err     = r_out_err;

endmodule

// File: tb/tb_thumb_cond_tracker.sv
// Directed, table-driven bench for thumb_cond_tracker plus hand-written
// stall, flush and reset sequences.
module tb_thumb_cond_tracker;
    import thumb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    thumb_cond_tracker_if bus();

    thumb_cond_tracker #(
        .T2_EN (1'b1),
        .IT_EN (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hw;
        logic        v;
        logic [31:0] inst;
        logic        is32;
        logic [1:0]  cls;
        logic [3:0]  cond;
        logic        in_it;
        logic        last;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t s16(input logic [15:0] hw, input logic [1:0] cls,
                                 input logic [3:0] cond, input logic in_it,
                                 input logic last, input logic err);
        vec_t r;
        r.hw = hw; r.v = 1'b1; r.inst = {16'h0000, hw}; r.is32 = 1'b0;
        r.cls = cls; r.cond = cond; r.in_it = in_it; r.last = last; r.err = err;
        return r;
    endfunction

    function automatic vec_t half(input logic [15:0] hw);
        vec_t r;
        r = s16(hw, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        r.v = 1'b0;
        return r;
    endfunction

    function automatic vec_t w32(input logic [15:0] hw2, input logic [31:0] inst,
                                 input logic [1:0] cls, input logic [3:0] cond,
                                 input logic in_it, input logic last, input logic err);
        vec_t r;
        r = s16(hw2, cls, cond, in_it, last, err);
        r.inst = inst;
        r.is32 = 1'b1;
        return r;
    endfunction

    task automatic check(input string name, input vec_t e);
        logic [42:0] act;
        logic [42:0] exp;
        logic        bad;
        act = {bus.out_valid, bus.out_inst, bus.out_is32, bus.out_class, bus.out_cond,
               bus.out_in_it, bus.out_it_last, bus.out_err};
        exp = {e.v, e.inst, e.is32, e.cls, e.cond, e.in_it, e.last, e.err};
        bad = e.v ? (act !== exp) : (bus.out_valid !== 1'b0);
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL %s: got v=%b inst=%h is32=%b cls=%0d cond=%h in_it=%b last=%b err=%b, want v=%b inst=%h is32=%b cls=%0d cond=%h in_it=%b last=%b err=%b",
                     name, act[42], act[41:10], act[9], act[8:7], act[6:3], act[2], act[1], act[0],
                     e.v, e.inst, e.is32, e.cls, e.cond, e.in_it, e.last, e.err);
        end else begin
            $display("ok   %s: v=%b inst=%h cls=%0d cond=%h in_it=%b last=%b err=%b",
                     name, act[42], act[41:10], act[8:7], act[6:3], act[2], act[1], act[0]);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end else begin
            $display("ok   %s: %b", name, act);
        end
    endtask

    task automatic check_reset(input string name);
        logic [43:0] act;
        act = {bus.out_valid, bus.out_inst, bus.out_is32, bus.out_class, bus.out_cond,
               bus.out_in_it, bus.out_it_last, bus.out_err, bus.in_ready};
        n_vec++;
        if (act !== 44'h0000_0000_001) begin
            n_err++;
            $display("FAIL %s: got outputs+in_ready=%h, want %h", name, act, 44'h0000_0000_001);
        end else begin
            $display("ok   %s: all outputs 0, in_ready 1", name);
        end
    endtask

    task automatic drive(input logic [15:0] hw);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_hw    = hw;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_hw     = 16'h0000;
        bus.out_ready = 1'b1;

        vecs.push_back(s16(16'hD012, 2'd1, 4'h0, 0, 0, 0));
        vecs.push_back(s16(16'hDE34, 2'd0, 4'hE, 0, 0, 0));
        vecs.push_back(s16(16'hDF56, 2'd0, 4'hE, 0, 0, 0));
        vecs.push_back(half(16'hF000));
        vecs.push_back(w32(16'h8000, 32'hF000_8000, 2'd1, 4'h0, 0, 0, 0));
        vecs.push_back(half(16'hF000));
        vecs.push_back(w32(16'h9000, 32'hF000_9000, 2'd2, 4'hE, 0, 0, 0));
        vecs.push_back(half(16'hF1C0));
        vecs.push_back(w32(16'h8000, 32'hF1C0_8000, 2'd1, 4'h7, 0, 0, 0));
        vecs.push_back(half(16'hF380));
        vecs.push_back(w32(16'h8000, 32'hF380_8000, 2'd0, 4'hE, 0, 0, 0));
        vecs.push_back(half(16'hE800));
        vecs.push_back(w32(16'h0000, 32'hE800_0000, 2'd0, 4'hE, 0, 0, 0));
        // ITTE EQ
        vecs.push_back(s16(16'hBF06, 2'd3, 4'hE, 0, 0, 0));
        vecs.push_back(s16(16'h2000, 2'd0, 4'h0, 1, 0, 0));
        vecs.push_back(s16(16'h2000, 2'd0, 4'h0, 1, 0, 0));
        vecs.push_back(s16(16'h2000, 2'd0, 4'h1, 1, 1, 0));
        vecs.push_back(s16(16'h2000, 2'd0, 4'hE, 0, 0, 0));
        // IT EQ then a conditional branch inside it
        vecs.push_back(s16(16'hBF08, 2'd3, 4'hE, 0, 0, 0));
        vecs.push_back(s16(16'hD1AB, 2'd1, 4'h0, 1, 1, 1));
        vecs.push_back(s16(16'h2000, 2'd0, 4'hE, 0, 0, 0));
        vecs.push_back(s16(16'hBF00, 2'd0, 4'hE, 0, 0, 0));
        vecs.push_back(s16(16'hE7FE, 2'd2, 4'hE, 0, 0, 0));
        vecs.push_back(s16(16'hDB05, 2'd1, 4'hB, 0, 0, 0));
        // ITE EQ with a nested IT in slot 1
        vecs.push_back(s16(16'hBF0C, 2'd3, 4'hE, 0, 0, 0));
        vecs.push_back(s16(16'hBF08, 2'd3, 4'h0, 1, 0, 1));
        vecs.push_back(s16(16'h2000, 2'd0, 4'h1, 1, 1, 0));
        // ITE EQ with B in both slots: error only when not last
        vecs.push_back(s16(16'hBF0C, 2'd3, 4'hE, 0, 0, 0));
        vecs.push_back(s16(16'hE000, 2'd2, 4'h0, 1, 0, 1));
        vecs.push_back(s16(16'hE000, 2'd2, 4'h1, 1, 1, 0));
        // IT AL (legal), IT with firstcond 1111 (flagged)
        vecs.push_back(s16(16'hBFE8, 2'd3, 4'hE, 0, 0, 0));
        vecs.push_back(s16(16'h2000, 2'd0, 4'hE, 1, 1, 0));
        vecs.push_back(s16(16'hBFF8, 2'd3, 4'hE, 0, 0, 1));
        vecs.push_back(s16(16'h2000, 2'd0, 4'hF, 1, 1, 0));

        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].hw);
            check($sformatf("vec%0d hw=%h", i, vecs[i].hw), vecs[i]);
        end

        // Output stall in the middle of an ITTE block
        drive(16'hBF06);
        check("stall it", s16(16'hBF06, 2'd3, 4'hE, 0, 0, 0));
        drive(16'h2000);
        check("stall slot0", s16(16'h2000, 2'd0, 4'h0, 1, 0, 0));
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall hold%0d", c), s16(16'h2000, 2'd0, 4'h0, 1, 0, 0));
            check_bit($sformatf("stall in_ready%0d", c), bus.in_ready, 1'b0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall slot1", s16(16'h2000, 2'd0, 4'h0, 1, 0, 0));
        drive(16'h2000);
        check("stall slot2", s16(16'h2000, 2'd0, 4'h1, 1, 1, 0));
        drive(16'h2000);
        check("stall after", s16(16'h2000, 2'd0, 4'hE, 0, 0, 0));

        // Flush while holding the first halfword of a 32-bit instruction
        drive(16'hF000);
        check("flushhalf prefix", half(16'hF000));
        @(negedge clk);
        flush     = 1'b1;
        bus.in_hw = 16'h8000;
        @(posedge clk);
        #1;
        check("flushhalf drop", half(16'h8000));
        @(negedge clk);
        flush = 1'b0;
        drive(16'h2000);
        check("flushhalf next", s16(16'h2000, 2'd0, 4'hE, 0, 0, 0));

        // Flush in the middle of an IT block
        drive(16'hBF06);
        check("flushit it", s16(16'hBF06, 2'd3, 4'hE, 0, 0, 0));
        drive(16'h2000);
        check("flushit slot0", s16(16'h2000, 2'd0, 4'h0, 1, 0, 0));
        @(negedge clk);
        flush     = 1'b1;
        bus.in_hw = 16'h2000;
        @(posedge clk);
        #1;
        check("flushit drop", half(16'h2000));
        @(negedge clk);
        flush = 1'b0;
        drive(16'h2000);
        check("flushit next", s16(16'h2000, 2'd0, 4'hE, 0, 0, 0));

        // Asynchronous reset while in HALF with an IT block open
        drive(16'hBF06);
        check("rst it", s16(16'hBF06, 2'd3, 4'hE, 0, 0, 0));
        drive(16'hF000);
        check("rst prefix", half(16'hF000));
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        check_reset("rst async");
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'h2000);
        check("rst next", s16(16'h2000, 2'd0, 4'hE, 0, 0, 0));

        @(negedge clk);
        bus.in_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
